// File: rtl/feistel_decrypt_core.sv
// feistel_decrypt_core
// Iterative Feistel decryptor. It undoes the encrypt-side cipher, one round per
// clock, applying rounds ROUNDS-1 down to 0. The round function and key schedule
// are the same ones the encrypt side uses.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   ciphertext and key are present
//   in_ready   core can accept a block (high only in IDLE)
//   in_data    ciphertext {L_N, R_N}, L in the upper half
//   in_key     key {key_hi, key_lo}
//   out_valid  plaintext is present
//   out_ready  downstream accepts the plaintext
//   out_data   plaintext {L_0, R_0}
//   busy       high in RUN or DONE
//   abort      (only with FEISTEL_DEC_ABORT_EN) drops the block in flight
//
// Build option
//   FEISTEL_DEC_ABORT_EN adds the abort input. When abort is high in RUN or
//   DONE, the core returns to IDLE at the next edge and clears out_valid and
//   the round counter. out_data keeps its value. abort takes priority over
//   out_ready and has no effect in IDLE.

module feistel_decrypt_core #(
   parameter int DATA_W = 32,
   parameter int ROUNDS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] in_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
`ifdef FEISTEL_DEC_ABORT_EN
   ,
   input  logic              abort
`endif
);

   localparam int HALF = DATA_W / 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [HALF-1:0]   l_q, l_d;
   logic [HALF-1:0]   r_q, r_d;
   logic [DATA_W-1:0] key_q, key_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q, in_ready_d;
   logic              busy_q, busy_d;

   logic [HALF-1:0]   round_key;
   logic [HALF-1:0]   f_out;

   // A rotation by 0 makes the right shift equal to HALF. That shift produces
   // zero, so the OR still returns x unchanged.
   function automatic logic [HALF-1:0] rotl(input logic [HALF-1:0] x, input int amt);
      int s;
      s = amt % HALF;
      return (x << s) | (x >> (HALF - s));
   endfunction

   // Round key for the current round: the size cast zero-extends or truncates
   // the round index to HALF bits.
   always_comb begin
      round_key = rotl(key_q[HALF-1:0], int'(cnt_q)) ^ key_q[DATA_W-1:HALF] ^ HALF'(cnt_q);
      f_out     = rotl(l_q ^ round_key, 3) + round_key;
   end

   // Next-state logic. Outputs are registered, so in_ready and busy are
   // updated together with the state transitions that change them.
   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      r_d         = r_q;
      key_d       = key_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               l_d        = in_data[DATA_W-1:HALF];
               r_d        = in_data[HALF-1:0];
               key_d      = in_key;
               cnt_d      = 8'(ROUNDS - 1);
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            l_d = r_q ^ f_out;
            r_d = l_q;
            if (cnt_q == 8'd0) begin
               // Round 0 result is the plaintext; capture it straight from the round logic.
               out_data_d  = {r_q ^ f_out, l_q};
               out_valid_d = 1'b1;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase

`ifdef FEISTEL_DEC_ABORT_EN
      // Abort overrides whatever RUN or DONE decided this cycle, out_ready included.
      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         out_valid_d = 1'b0;
         cnt_d       = 8'd0;
         in_ready_d  = 1'b1;
         busy_d      = 1'b0;
      end
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         l_q         <= '0;
         r_q         <= '0;
         key_q       <= '0;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         r_q         <= r_d;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_feistel_decrypt_core.sv
// tb_feistel_decrypt_core
// Testbench for feistel_decrypt_core. The main instance uses the default
// parameters. A second instance is built with ROUNDS=1 to check a known vector.
// The bench encrypts a plaintext with its own reference model and feeds the
// resulting ciphertext to the core. The plaintext is queued as the expected
// result and compared when the core delivers its output.

module tb_feistel_decrypt_core;

   logic        clk;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0] in_data, in_key, out_data;
   logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
   logic [31:0] in_data1, in_key1, out_data1;
`ifdef FEISTEL_DEC_ABORT_EN
   logic        abort;
   logic        abort1;
`endif

   int          nCompared;
   int          nMismatched;
   int          nTransfers;
   logic [31:0] sbq[$];

   feistel_decrypt_core #(.DATA_W(32), .ROUNDS(16)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
`ifdef FEISTEL_DEC_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   feistel_decrypt_core #(.DATA_W(32), .ROUNDS(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid1),
      .in_ready  (in_ready1),
      .in_data   (in_data1),
      .in_key    (in_key1),
      .out_valid (out_valid1),
      .out_ready (out_ready1),
      .out_data  (out_data1),
      .busy      (busy1)
`ifdef FEISTEL_DEC_ABORT_EN
      ,
      .abort     (abort1)
`endif
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts every completed output handshake on the main instance.
   always @(posedge clk) begin
      if (out_valid && out_ready) nTransfers <= nTransfers + 1;
   end

   // Hard time limit so a stuck core cannot hang the run.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: this is the encrypt direction, written independently of the core.
   function automatic logic [15:0] mRotl(input logic [15:0] x, input int s);
      logic [15:0] y;
      y = '0;
      for (int b = 0; b < 16; b++) y[(b + s) % 16] = x[b];
      return y;
   endfunction

   function automatic logic [15:0] mRoundKey(input logic [31:0] key, input int i);
      return mRotl(key[15:0], i % 16) ^ key[31:16] ^ 16'(i);
   endfunction

   function automatic logic [15:0] mF(input logic [15:0] x, input logic [15:0] k);
      return mRotl(x ^ k, 3) + k;
   endfunction

   function automatic logic [31:0] mEncrypt(input logic [31:0] pt, input logic [31:0] key);
      logic [15:0] l, r, nl, nr;
      l = pt[31:16];
      r = pt[15:0];
      for (int i = 0; i < 16; i++) begin
         nl = r;
         nr = l ^ mF(r, mRoundKey(key, i));
         l  = nl;
         r  = nr;
      end
      return {l, r};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives one ciphertext block into the main instance and queues the expected plaintext.
   // The inputs are scrambled right after the accept edge to show they are no longer used.
   task automatic applyStimulus(input logic [31:0] pt, input logic [31:0] key);
      int waitCycles;
      waitCycles = 0;
      while (!in_ready && waitCycles < 40) begin
         tick();
         waitCycles++;
      end
      if (!in_ready) begin
         checkOutput("accept_timeout", 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_data  = mEncrypt(pt, key);
      in_key   = key;
      tick();
      in_valid = 1'b0;
      in_data  = $urandom;
      in_key   = $urandom;
      sbq.push_back(pt);
      checkOutput("in_ready_low_after_accept", 32'(in_ready), 32'd0);
      checkOutput("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Waits for out_valid, optionally holds back-pressure, then pops and compares the result.
   // pokeReady raises out_ready during RUN, where it must have no effect.
   task automatic runToOutput(input int holdCycles, input bit pokeReady);
      int          lat;
      logic [31:0] held;
      logic [31:0] exp;
      int          xferBefore;
      lat = 0;
      if (pokeReady) out_ready = 1'b1;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      out_ready = 1'b0;
      checkOutput("latency", 32'(lat), 32'd16);
      if (!out_valid) return;
      held = out_data;
      in_valid = 1'b1;
      for (int c = 0; c < holdCycles; c++) begin
         tick();
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_out_data", out_data, held);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      if (sbq.size() == 0) begin
         checkOutput("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      exp = sbq.pop_front();
      checkOutput("plaintext", out_data, exp);
      xferBefore = nTransfers;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checkOutput("one_transfer", 32'(nTransfers - xferBefore), 32'd1);
      checkOutput("out_valid_cleared", 32'(out_valid), 32'd0);
      checkOutput("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] pt, key;
      nCompared   = 0;
      nMismatched = 0;
      nTransfers  = 0;
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_key = '0; out_ready = 1'b0;
      in_valid1 = 1'b0; in_data1 = '0; in_key1 = '0; out_ready1 = 1'b0;
`ifdef FEISTEL_DEC_ABORT_EN
      abort = 1'b0;
      abort1 = 1'b0;
`endif

      // Reset is held for two cycles, then the reset values are checked.
      tick();
      tick();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_out_data", out_data, 32'd0);
      rst = 1'b0;
      tick();

      // Known vector on the ROUNDS=1 instance.
      in_valid1 = 1'b1;
      in_data1  = 32'h0001_0000;
      in_key1   = 32'h0;
      tick();
      in_valid1 = 1'b0;
      checkOutput("r1_valid_early", 32'(out_valid1), 32'd0);
      tick();
      checkOutput("r1_valid", 32'(out_valid1), 32'd1);
      checkOutput("r1_data", out_data1, 32'h0008_0001);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      checkOutput("r1_valid_clr", 32'(out_valid1), 32'd0);
      checkOutput("r1_in_ready", 32'(in_ready1), 32'd1);

      // Random round trips. The second block raises out_ready during RUN, where it must be ignored.
      for (int n = 0; n < 4; n++) begin
         pt  = $urandom;
         key = $urandom;
         applyStimulus(pt, key);
         runToOutput(0, n == 1);
      end

      // Corner keys and data.
      applyStimulus(32'h0000_0000, 32'hFFFF_FFFF);
      runToOutput(0, 1'b0);
      applyStimulus(32'hFFFF_FFFF, 32'h0000_0000);
      runToOutput(0, 1'b0);

      // Back-pressure: out_ready is held low for 10 cycles in DONE.
      applyStimulus(32'hDEAD_BEEF, 32'h1234_5678);
      runToOutput(10, 1'b0);

      // Reset pulsed mid-RUN. The block is dropped and the next one must still decrypt.
      applyStimulus(32'hCAFE_F00D, 32'h0BAD_C0DE);
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_out_data", out_data, 32'd0);
      if (sbq.size() > 0) void'(sbq.pop_back());
      applyStimulus(32'h5A5A_A5A5, 32'h0F0F_F0F0);
      runToOutput(0, 1'b0);

`ifdef FEISTEL_DEC_ABORT_EN
      begin
         int          xferBefore;
         logic [31:0] lastData;
         bit          sawValid;
         // Abort during RUN: the core returns to IDLE and never raises out_valid.
         lastData = out_data;
         applyStimulus(32'h1357_9BDF, 32'h2468_ACE0);
         repeat (3) tick();
         abort = 1'b1;
         tick();
         abort = 1'b0;
         checkOutput("abort_run_in_ready", 32'(in_ready), 32'd1);
         checkOutput("abort_run_busy", 32'(busy), 32'd0);
         checkOutput("abort_run_out_data", out_data, lastData);
         sawValid = 1'b0;
         for (int c = 0; c < 20; c++) begin
            if (out_valid) sawValid = 1'b1;
            tick();
         end
         checkOutput("abort_run_no_valid", 32'(sawValid), 32'd0);
         if (sbq.size() > 0) void'(sbq.pop_back());

         // Abort and out_ready together in DONE: abort wins and no transfer is counted.
         applyStimulus(32'h0F1E_2D3C, 32'h4B5A_6978);
         while (!out_valid) tick();
         lastData   = out_data;
         xferBefore = nTransfers;
         abort     = 1'b1;
         out_ready = 1'b1;
         tick();
         abort     = 1'b0;
         out_ready = 1'b0;
         checkOutput("abort_done_valid", 32'(out_valid), 32'd0);
         checkOutput("abort_done_xfer", 32'(nTransfers - xferBefore), 32'd0);
         checkOutput("abort_done_data", out_data, lastData);
         checkOutput("abort_done_in_ready", 32'(in_ready), 32'd1);
         if (sbq.size() > 0) void'(sbq.pop_back());
      end
`endif

      checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
